// File: rtl/gcd_job_ctrl.sv
// gcd_job_ctrl: job sequencer between the Basys3 key/switch inputs and the GCD core.
// A debounced key press snapshots the two 8-bit operands and launches one core job.
// Completion latches the result. Both-zero requests are rejected, and one press
// arriving mid-job is buffered.
// Optional watchdog: define GCD_TIMEOUT_EN to build the WAIT-state timeout counter.
// Without it, err_timeout is tied low and WAIT exits only on core_done or reset.

module gcd_job_ctrl #(
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_in,
    input  logic [7:0]  op_a_in,
    input  logic [7:0]  op_b_in,
    output logic        core_start,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic        core_done,
    input  logic [31:0] core_result,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err_zero,
    output logic        err_timeout,
    output logic [7:0]  job_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2
    } state_e;

    state_e      state_q;
    logic        key_q;
    logic        press;
    logic        pend_q;
    logic [7:0]  pend_a_q;
    logic [7:0]  pend_b_q;
    logic [7:0]  req_a;
    logic [7:0]  req_b;
    logic        core_start_q;
    logic [31:0] core_a_q;
    logic [31:0] core_b_q;
    logic [31:0] result_q;
    logic        result_valid_q;
    logic        busy_q;
    logic        err_zero_q;
    logic [7:0]  job_cnt_q;

`ifdef GCD_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic             err_timeout_q;
`endif

    // A request is a fresh key edge; a held key never re-triggers.
    assign press = key_in & ~key_q;

    // A buffered request always wins over the live switches.
    assign req_a = pend_q ? pend_a_q : op_a_in;
    assign req_b = pend_q ? pend_b_q : op_b_in;

    // Job sequencer: key edge detect, pending slot, FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            key_q          <= 1'b0;
            pend_q         <= 1'b0;
            pend_a_q       <= 8'd0;
            pend_b_q       <= 8'd0;
            core_start_q   <= 1'b0;
            core_a_q       <= 32'd0;
            core_b_q       <= 32'd0;
            result_q       <= 32'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            err_zero_q     <= 1'b0;
            job_cnt_q      <= 8'd0;
`ifdef GCD_TIMEOUT_EN
            wd_cnt_q       <= '0;
            err_timeout_q  <= 1'b0;
`endif
        end else begin
            key_q        <= key_in;
            core_start_q <= 1'b0;

            // Presses during a job land in the single pending slot (last one wins).
            if (press && busy_q) begin
                pend_q   <= 1'b1;
                pend_a_q <= op_a_in;
                pend_b_q <= op_b_in;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (pend_q || press) begin
                        pend_q <= 1'b0;
                        if ((req_a == 8'd0) && (req_b == 8'd0)) begin
                            err_zero_q <= 1'b1;
                        end else begin
                            core_a_q       <= {24'd0, req_a};
                            core_b_q       <= {24'd0, req_b};
                            err_zero_q     <= 1'b0;
                            result_valid_q <= 1'b0;
                            core_start_q   <= 1'b1;
                            busy_q         <= 1'b1;
                            state_q        <= ST_LAUNCH;
`ifdef GCD_TIMEOUT_EN
                            err_timeout_q  <= 1'b0;
`endif
                        end
                    end
                end

                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
`ifdef GCD_TIMEOUT_EN
                    wd_cnt_q <= '0;
`endif
                end

                ST_WAIT: begin
                    if (core_done) begin
                        result_q       <= core_result;
                        result_valid_q <= 1'b1;
                        job_cnt_q      <= job_cnt_q + 8'd1;
                        busy_q         <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (wd_cnt_q == WD_LAST) begin
                        err_timeout_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
`endif
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign core_start   = core_start_q;
    assign core_a       = core_a_q;
    assign core_b       = core_b_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign err_zero     = err_zero_q;
    assign job_cnt      = job_cnt_q;

`ifdef GCD_TIMEOUT_EN
    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_job_ctrl.sv
// tb_gcd_job_ctrl: directed bench for gcd_job_ctrl with a small behavioural GCD core.
// The core answers a configurable number of cycles after core_start (0 = never answers).

module tb_gcd_job_ctrl;

    localparam int TOUT = 16;

    logic        clk;
    logic        rst_n;
    logic        key_in;
    logic [7:0]  op_a_in;
    logic [7:0]  op_b_in;
    logic        core_start;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic        core_done;
    logic [31:0] core_result;
    logic [31:0] result;
    logic        result_valid;
    logic        busy;
    logic        err_zero;
    logic        err_timeout;
    logic [7:0]  job_cnt;

    int total = 0;
    int bad = 0;
    int coreLatency = 1;
    int doneCountdown = 0;
    int startCount = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [31:0] expRes;
    } vec_t;

    vec_t vecs[7];

    gcd_job_ctrl #(.TIMEOUT_CYC(TOUT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_in       (key_in),
        .op_a_in      (op_a_in),
        .op_b_in      (op_b_in),
        .core_start   (core_start),
        .core_a       (core_a),
        .core_b       (core_b),
        .core_done    (core_done),
        .core_result  (core_result),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .err_zero     (err_zero),
        .err_timeout  (err_timeout),
        .job_cnt      (job_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] gcdRef(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = x;
        b = y;
        while (b != 32'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Behavioural core: one-cycle done pulse coreLatency cycles after core_start.
    initial begin
        core_done = 1'b0;
        core_result = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            core_done = 1'b0;
            if (doneCountdown > 0) begin
                doneCountdown = doneCountdown - 1;
                if (doneCountdown == 0) begin
                    core_done = 1'b1;
                    core_result = gcdRef(core_a, core_b);
                end
            end
            if (core_start) doneCountdown = coreLatency;
        end
    end

    // Counts every cycle in which core_start is high.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            if (core_start) startCount = startCount + 1;
        end
    end

    // Global time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout act=running exp=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("[TB] FAIL %s act=%0d exp=%0d", name, act, exp);
        end
    endtask

    // One key press: raise key for one sampled edge, then release.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input int lat);
        coreLatency = lat;
        op_a_in = a;
        op_b_in = b;
        key_in = 1'b1;
        tick();
        key_in = 1'b0;
    endtask

    task automatic waitBusyLow(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n = n + 1;
        end
        if (busy !== 1'b0) begin
            total = total + 1;
            bad = bad + 1;
            $display("[TB] FAIL %s act=busy_after_%0d_cycles exp=idle", name, budget);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int expJobs;
        int s0;
        logic [31:0] prevRes;

        vecs[0] = '{a: 8'd12,  b: 8'd18,  lat: 5, expRes: 32'd6};
        vecs[1] = '{a: 8'd7,   b: 8'd0,   lat: 1, expRes: 32'd7};
        vecs[2] = '{a: 8'd255, b: 8'd255, lat: 3, expRes: 32'd255};
        vecs[3] = '{a: 8'd48,  b: 8'd36,  lat: 1, expRes: 32'd12};
        vecs[4] = '{a: 8'd1,   b: 8'd200, lat: 4, expRes: 32'd1};
        vecs[5] = '{a: 8'd100, b: 8'd75,  lat: 2, expRes: 32'd25};
        vecs[6] = '{a: 8'd17,  b: 8'd51,  lat: 6, expRes: 32'd17};

        rst_n = 1'b0;
        key_in = 1'b0;
        op_a_in = 8'd0;
        op_b_in = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;

        checkOutput("rst_core_start", {31'd0, core_start}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_job_cnt", {24'd0, job_cnt}, 32'd0);
        checkOutput("rst_err_zero", {31'd0, err_zero}, 32'd0);
        checkOutput("rst_core_a", core_a, 32'd0);

        // Table-driven single jobs.
        expJobs = 0;
        for (int i = 0; i < 7; i++) begin
            s0 = startCount;
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].lat);
            checkOutput($sformatf("v%0d_core_start", i), {31'd0, core_start}, 32'd1);
            checkOutput($sformatf("v%0d_core_a", i), core_a, {24'd0, vecs[i].a});
            checkOutput($sformatf("v%0d_core_b", i), core_b, {24'd0, vecs[i].b});
            checkOutput($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd1);
            checkOutput($sformatf("v%0d_valid_cleared", i), {31'd0, result_valid}, 32'd0);
            waitBusyLow($sformatf("v%0d_wait", i), 50);
            expJobs = expJobs + 1;
            checkOutput($sformatf("v%0d_result", i), result, vecs[i].expRes);
            checkOutput($sformatf("v%0d_valid", i), {31'd0, result_valid}, 32'd1);
            checkOutput($sformatf("v%0d_job_cnt", i), {24'd0, job_cnt}, expJobs);
            checkOutput($sformatf("v%0d_starts", i), startCount - s0, 32'd1);
            tick();
        end

        // Minimum latency: done in the first WAIT cycle.
        applyStimulus(8'd9, 8'd3, 1);
        tick();
        checkOutput("minlat_valid_early", {31'd0, result_valid}, 32'd0);
        checkOutput("minlat_busy_early", {31'd0, busy}, 32'd1);
        tick();
        expJobs = expJobs + 1;
        checkOutput("minlat_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("minlat_result", result, 32'd3);
        tick();

        // Both-zero request is rejected, then a one-zero request launches.
        s0 = startCount;
        applyStimulus(8'd0, 8'd0, 1);
        checkOutput("zero_err", {31'd0, err_zero}, 32'd1);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        checkOutput("zero_result_kept", result, 32'd3);
        tick();
        tick();
        checkOutput("zero_no_start", startCount - s0, 32'd0);
        applyStimulus(8'd0, 8'd7, 2);
        checkOutput("zero_b7_start", {31'd0, core_start}, 32'd1);
        checkOutput("zero_err_cleared", {31'd0, err_zero}, 32'd0);
        waitBusyLow("zero_b7_wait", 50);
        expJobs = expJobs + 1;
        checkOutput("zero_b7_result", result, 32'd7);
        tick();

        // Press during WAIT is buffered and relaunched after one idle cycle.
        applyStimulus(8'd48, 8'd36, 5);
        tick();
        tick();
        applyStimulus(8'd9, 8'd6, 5);
        waitBusyLow("pend_first_wait", 50);
        expJobs = expJobs + 1;
        checkOutput("pend_first_result", result, 32'd12);
        checkOutput("pend_first_job_cnt", {24'd0, job_cnt}, expJobs);
        tick();
        checkOutput("pend_relaunch_start", {31'd0, core_start}, 32'd1);
        checkOutput("pend_relaunch_a", core_a, 32'd9);
        checkOutput("pend_relaunch_b", core_b, 32'd6);
        waitBusyLow("pend_second_wait", 50);
        expJobs = expJobs + 1;
        checkOutput("pend_second_result", result, 32'd3);
        checkOutput("pend_second_job_cnt", {24'd0, job_cnt}, expJobs);
        tick();

        // Core never answers.
        prevRes = result;
        applyStimulus(8'd3, 8'd9, 0);
        tick();
        repeat (TOUT - 1) tick();
        checkOutput("tout_busy_before", {31'd0, busy}, 32'd1);
        checkOutput("tout_err_before", {31'd0, err_timeout}, 32'd0);
        tick();
`ifdef GCD_TIMEOUT_EN
        checkOutput("tout_err", {31'd0, err_timeout}, 32'd1);
        checkOutput("tout_busy", {31'd0, busy}, 32'd0);
`else
        checkOutput("tout_err_off", {31'd0, err_timeout}, 32'd0);
        checkOutput("tout_busy_stuck", {31'd0, busy}, 32'd1);
`endif
        checkOutput("tout_result_kept", result, prevRes);
        doReset();

        // Reset during WAIT abandons the job; the late done is ignored.
        applyStimulus(8'd20, 8'd8, 4);
        tick();
        rst_n = 1'b0;
        tick();
        checkOutput("rwait_core_start", {31'd0, core_start}, 32'd0);
        checkOutput("rwait_core_a", core_a, 32'd0);
        checkOutput("rwait_core_b", core_b, 32'd0);
        checkOutput("rwait_busy", {31'd0, busy}, 32'd0);
        checkOutput("rwait_result", result, 32'd0);
        checkOutput("rwait_job_cnt", {24'd0, job_cnt}, 32'd0);
        checkOutput("rwait_err_timeout", {31'd0, err_timeout}, 32'd0);
        rst_n = 1'b1;
        repeat (6) tick();
        checkOutput("rwait_late_result", result, 32'd0);
        checkOutput("rwait_late_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rwait_late_job_cnt", {24'd0, job_cnt}, 32'd0);

        // Key held for 1000 cycles launches exactly one job.
        s0 = startCount;
        coreLatency = 3;
        op_a_in = 8'd5;
        op_b_in = 8'd10;
        key_in = 1'b1;
        repeat (1000) tick();
        key_in = 1'b0;
        tick();
        checkOutput("hold_starts", startCount - s0, 32'd1);
        checkOutput("hold_result", result, 32'd5);
        checkOutput("hold_job_cnt", {24'd0, job_cnt}, 32'd1);

        // Job counter wraps 255 -> 0.
        for (int j = 0; j < 254; j++) begin
            applyStimulus(8'd6, 8'd4, 1);
            waitBusyLow("wrap_wait", 50);
        end
        checkOutput("wrap_cnt_255", {24'd0, job_cnt}, 32'd255);
        applyStimulus(8'd14, 8'd21, 1);
        waitBusyLow("wrap_last_wait", 50);
        checkOutput("wrap_cnt_0", {24'd0, job_cnt}, 32'd0);
        checkOutput("wrap_result", result, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
